// File: rtl/fir_tdf_param.sv
// rtl/fir_tdf_param.sv - transposed-direct-form FIR, loadable coefficients, optional saturation (FIR_TDF_SAT_EN)
module fir_tdf_param #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int TAPS  = 51,
  parameter int SHIFT = 0,
  parameter int AW    = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 coef_wr_en,
  input  logic [AW-1:0]        coef_wr_addr,
  input  logic signed [CW-1:0] coef_wr_data,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] data_in,
  output logic                 out_valid,
  output logic signed [DW-1:0] data_out,
  output logic                 out_sat
);

  // Accumulator is wide enough that no product or partial sum can overflow.
  localparam int ACC_W = DW + CW + $clog2(TAPS);

  logic signed [CW-1:0]    coef [TAPS];
  logic signed [ACC_W-1:0] z    [1:TAPS-1];
  logic signed [ACC_W-1:0] prod [TAPS];
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic signed [DW-1:0]    data_next;
  logic                    sat_next;

  // Sample times every coefficient, sign-extended so truncation to ACC_W is exact.
  always_comb begin
    x_ext = {{(ACC_W-DW){data_in[DW-1]}}, data_in};
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = x_ext * {{(ACC_W-CW){coef[k][CW-1]}}, coef[k]};
    end
    sum     = prod[0] + z[1];
    shifted = sum >>> SHIFT;
  end

`ifdef FIR_TDF_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Clamp the scaled result into the DW-bit signed range and flag when it happens.
  always_comb begin
    data_next = DW'(shifted);
    sat_next  = 1'b0;
    if (shifted > MAX_V) begin
      data_next = DW'(MAX_V);
      sat_next  = 1'b1;
    end else if (shifted < MIN_V) begin
      data_next = DW'(MIN_V);
      sat_next  = 1'b1;
    end
  end
`else
  // Keep the low DW bits of the scaled result (two's-complement wrap), never flag.
  always_comb begin
    data_next = DW'(shifted);
    sat_next  = 1'b0;
  end
`endif

  // Coefficient bank: out-of-range addresses match no tap and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        if (coef_wr_en && coef_wr_addr == AW'(k)) coef[k] <= coef_wr_data;
      end
    end
  end

  // Partial-sum chain advances only on accepted samples; clr flushes it and drops the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < TAPS; k++) z[k] <= '0;
    end else if (clr) begin
      for (int k = 1; k < TAPS; k++) z[k] <= '0;
    end else if (in_valid) begin
      for (int k = 1; k < TAPS - 1; k++) z[k] <= prod[k] + z[k+1];
      z[TAPS-1] <= prod[TAPS-1];
    end
  end

  // Output stage: one-cycle valid pulse per accepted sample, data and flag hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_sat   <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      data_out  <= data_next;
      out_sat   <= sat_next;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_tdf_param.sv
// tb/tb_fir_tdf_param.sv - directed self-checking bench for fir_tdf_param
module tb_fir_tdf_param;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               coef_wr_en = 1'b0;
  logic [5:0]         coef_wr_addr = '0;
  logic signed [15:0] coef_wr_data = '0;
  logic               clr = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] data_in = '0;
  logic               out_valid;
  logic signed [15:0] data_out;
  logic               out_sat;

  logic               s_wr_en = 1'b0;
  logic [1:0]         s_wr_addr = '0;
  logic signed [15:0] s_wr_data = '0;
  logic               s_valid = 1'b0;
  logic signed [15:0] s_x = '0;
  logic               s_out_valid;
  logic signed [15:0] s_out;
  logic               s_out_sat;

  int n_cmp = 0;
  int n_err = 0;

  fir_tdf_param u_dut (
    .clk(clk), .rst_n(rst_n),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .clr(clr), .in_valid(in_valid), .data_in(data_in),
    .out_valid(out_valid), .data_out(data_out), .out_sat(out_sat)
  );

  fir_tdf_param #(.TAPS(4), .SHIFT(15)) u_dut_sh (
    .clk(clk), .rst_n(rst_n),
    .coef_wr_en(s_wr_en), .coef_wr_addr(s_wr_addr), .coef_wr_data(s_wr_data),
    .clr(1'b0), .in_valid(s_valid), .data_in(s_x),
    .out_valid(s_out_valid), .data_out(s_out), .out_sat(s_out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int c_exp(input int k);
    if (k > 50) return 0;
    return (k <= 25) ? k : 50 - k;
  endfunction

  task automatic sample(input logic v, input logic signed [15:0] x, input logic c);
    in_valid = v;
    data_in  = x;
    clr      = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic write_coef(input int a, input int d);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 6'(a);
    coef_wr_data = 16'(d);
    @(posedge clk);
    #1;
    coef_wr_en = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    check("rst_data", data_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sat", out_sat, 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // impulse response
    for (int k = 0; k < 51; k++) write_coef(k, c_exp(k));
    for (int i = 0; i < 53; i++) begin
      sample(1'b1, (i == 0) ? 16'sd1 : 16'sd0, 1'b0);
      check($sformatf("imp_data[%0d]", i), data_out, c_exp(i));
      check($sformatf("imp_valid[%0d]", i), out_valid, 1);
    end
    sample(1'b0, 16'sd0, 1'b0);
    check("imp_idle_valid", out_valid, 0);

    // stall: alternate accepted samples and idle gaps
    for (int i = 0; i < 10; i++) begin
      sample(1'b1, (i == 0) ? 16'sd1 : 16'sd0, 1'b0);
      check($sformatf("stall_data[%0d]", i), data_out, c_exp(i));
      check($sformatf("stall_valid[%0d]", i), out_valid, 1);
      sample(1'b0, 16'sd77, 1'b0);
      check($sformatf("stall_hold[%0d]", i), data_out, c_exp(i));
      check($sformatf("stall_gap[%0d]", i), out_valid, 0);
    end

    // flush: clr with a simultaneous sample drops it and empties the line
    sample(1'b0, 16'sd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sample(1'b1, (i == 0) ? 16'sd1 : 16'sd0, 1'b0);
      check($sformatf("flush_pre[%0d]", i), data_out, c_exp(i));
    end
    sample(1'b1, 16'sd100, 1'b1);
    check("flush_clr_valid", out_valid, 0);
    check("flush_clr_hold", data_out, 2);
    check("flush_clr_sat", out_sat, 0);
    for (int i = 0; i < 51; i++) begin
      sample(1'b1, 16'sd0, 1'b0);
      check($sformatf("flush_post[%0d]", i), data_out, 0);
    end

    // live reload
    for (int k = 1; k < 51; k++) write_coef(k, 0);
    write_coef(0, 5);
    sample(1'b0, 16'sd0, 1'b1);
    coef_wr_en = 1'b1; coef_wr_addr = 6'd0; coef_wr_data = 16'sd7;
    sample(1'b1, 16'sd3, 1'b0);
    coef_wr_en = 1'b0;
    check("reload_old", data_out, 15);
    sample(1'b1, 16'sd3, 1'b0);
    check("reload_new", data_out, 21);
    write_coef(60, 99);
    sample(1'b1, 16'sd3, 1'b0);
    check("reload_oob", data_out, 21);
    for (int i = 0; i < 51; i++) begin
      sample(1'b1, 16'sd0, 1'b0);
      check($sformatf("reload_tail[%0d]", i), data_out, 0);
    end

    // saturation / wrap of the full-scale product
    for (int k = 0; k < 51; k++) write_coef(k, 32767);
    sample(1'b0, 16'sd0, 1'b1);
    sample(1'b1, 16'sd32767, 1'b0);
`ifdef FIR_TDF_SAT_EN
    check("sat_data", data_out, 32767);
    check("sat_flag", out_sat, 1);
`else
    check("wrap_data", data_out, 1);
    check("wrap_flag", out_sat, 0);
`endif
    sample(1'b0, 16'sd0, 1'b1);

    // SHIFT=15 instance
    s_wr_en = 1'b1; s_wr_addr = 2'd0; s_wr_data = 16'sd16384;
    @(posedge clk); #1;
    s_wr_en = 1'b0;
    s_valid = 1'b1; s_x = 16'sd16384;
    @(posedge clk); #1;
    check("shift_pos", s_out, 8192);
    check("shift_valid", s_out_valid, 1);
    s_x = -16'sd16384;
    @(posedge clk); #1;
    check("shift_neg", s_out, -8192);
    check("shift_sat", s_out_sat, 0);
    s_valid = 1'b0;

    // asynchronous reset mid-stream
    sample(1'b1, 16'sd1, 1'b0);
    check("mid_pre_data", data_out, 32767);
    check("mid_pre_valid", out_valid, 1);
    in_valid = 1'b1; data_in = 16'sd1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", data_out, 0);
    check("mid_rst_valid", out_valid, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample(1'b1, (i == 0) ? 16'sd1 : 16'sd0, 1'b0);
      check($sformatf("post_rst_data[%0d]", i), data_out, 0);
      check($sformatf("post_rst_valid[%0d]", i), out_valid, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
